// File: rtl/rv32i_ifetch_pkg.sv
// Shared definitions for the RV32I instruction fetch stage.
//   NOP_INSTR        - addi x0,x0,0, shown to decode before the first fetch completes
//   RESET_PC_DEFAULT - default reset PC
//   if_state_e       - fetch FSM states (request / wait for response / hold for decode)
//   pc_sel_e         - next-pc mux select for rv32i_pc_reg
package rv32i_ifetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IfStReq  = 2'd0,
        IfStWait = 2'd1,
        IfStHold = 2'd2
    } if_state_e;

    typedef enum logic [1:0] {
        PcHold     = 2'd0,
        PcInc      = 2'd1,
        PcRedirect = 2'd2
    } pc_sel_e;

    // Redirect targets are forced onto a word boundary; no misalign trap exists.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv32i_pc_reg.sv
// Program counter register with next-pc mux.
//   clk, rst      - clock, asynchronous active-high reset (loads RESET_PC)
//   sel_i         - pc_sel_e: hold / advance by 4 / load word-aligned redirect target
//   redirect_pc_i - redirect target (low two bits ignored)
//   pc_o          - current PC
module rv32i_pc_reg
    import rv32i_ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  sel_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        case (sel_i)
            PcInc:      pc_d = pc_q + 32'd4;  // wraps modulo 2^32
            PcRedirect: pc_d = word_align(redirect_pc_i);
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/rv32i_ifetch.sv
// RV32I instruction fetch stage. Issues one word request at a time, buffers the
// response for decode and restarts at the target on a redirect from execute.
//   clk, rst                        - clock, asynchronous active-high reset
//   imem_req_valid/ready/addr       - fetch request (addr = pc)
//   imem_rsp_valid/data             - fetch response, one per accepted request
//   redirect_valid/redirect_pc      - taken branch / JAL / JALR target
//   instr_valid/instr_ready         - handshake to decode
//   instr, instr_pc, instr_pc_plus4 - fetched word, its PC and link value
module rv32i_ifetch
    import rv32i_ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4
);

    if_state_e   state_q, state_d;
    logic        drop_q, drop_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] instr_pc_plus4_q, instr_pc_plus4_d;
    pc_sel_e     pc_sel;
    logic [31:0] pc;
    logic        req_valid;

    rv32i_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .sel_i         (pc_sel),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc)
    );

    // A redirect cycle never issues a request: the PC is about to change.
    assign req_valid = (state_q == IfStReq) && !redirect_valid && !rst;

    always_comb begin
        state_d          = state_q;
        drop_d           = drop_q;
        pc_sel           = PcHold;
        instr_valid_d    = instr_valid_q;
        instr_d          = instr_q;
        instr_pc_d       = instr_pc_q;
        instr_pc_plus4_d = instr_pc_plus4_q;

        unique case (state_q)
            IfStReq: begin
                if (redirect_valid) begin
                    pc_sel = PcRedirect;
                end else if (req_valid && imem_req_ready) begin
                    state_d = IfStWait;
                end
            end
            IfStWait: begin
                if (imem_rsp_valid) begin
                    if (drop_q || redirect_valid) begin
                        // Wrong-path response; pc already holds (or now takes) the target.
                        drop_d  = 1'b0;
                        state_d = IfStReq;
                        if (redirect_valid) begin
                            pc_sel = PcRedirect;
                        end
                    end else begin
                        instr_d          = imem_rsp_data;
                        instr_pc_d       = pc;
                        instr_pc_plus4_d = pc + 32'd4;
                        instr_valid_d    = 1'b1;
                        pc_sel           = PcInc;
                        state_d          = IfStHold;
                    end
                end else if (redirect_valid) begin
                    // Response still in flight: remember to discard it.
                    pc_sel = PcRedirect;
                    drop_d = 1'b1;
                end
            end
            IfStHold: begin
                // Redirect takes priority over a same-cycle consume.
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    pc_sel        = PcRedirect;
                    state_d       = IfStReq;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = IfStReq;
                end
            end
            default: begin
                state_d = IfStReq;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IfStReq;
            drop_q           <= 1'b0;
            instr_valid_q    <= 1'b0;
            instr_q          <= NOP_INSTR;
            instr_pc_q       <= 32'd0;
            instr_pc_plus4_q <= 32'd4;
        end else begin
            state_q          <= state_d;
            drop_q           <= drop_d;
            instr_valid_q    <= instr_valid_d;
            instr_q          <= instr_d;
            instr_pc_q       <= instr_pc_d;
            instr_pc_plus4_q <= instr_pc_plus4_d;
        end
    end

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign instr_pc_plus4 = instr_pc_plus4_q;

endmodule

// File: tb/tb_rv32i_ifetch.sv
// Self-checking bench for rv32i_ifetch: a cycle table, directed corner sequences
// and a randomized run checked against a fetch-stream reference model.
module tb_rv32i_ifetch;
    import rv32i_ifetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    int checks   = 0;
    int failures = 0;

    rv32i_ifetch #(
        .RESET_PC (32'h0000_0000),
        .XLEN     (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents; address 0x8 holds addi x1,x0,5.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0033;
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic mem_pend;
    logic [31:0] mem_addr;
    int mem_wait;
    int mem_lat;   // extra cycles beyond the minimum one-cycle response
    bit mem_rand;

    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        mem_pend = 1'b0;
        mem_addr = 32'd0;
        mem_wait = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (imem_rsp_valid) mem_pend = 1'b0;
                if (imem_req_valid && imem_req_ready) begin
                    mem_pend = 1'b1;
                    mem_addr = imem_req_addr;
                    mem_wait = mem_lat;
                end
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (mem_pend && !rst) begin
                if (mem_wait == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(mem_addr);
                end else begin
                    mem_wait--;
                end
            end
            imem_req_ready = mem_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // A response may only arrive while the fetch stage is waiting for one.
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && (imem_req_valid || instr_valid)))
            else begin
                failures++;
                $display("FAIL rsp_protocol: rsp_valid=1 with req_valid=%0b instr_valid=%0b",
                         imem_req_valid, instr_valid);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_neg(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        @(negedge clk);
    endtask

    // Async reset pulse placed between clock edges; memory is reset alongside.
    task automatic pulse_reset();
        redirect_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, NOP_INSTR);
        mem_pend = 1'b0;
        imem_rsp_valid = 1'b0;
        #1 rst = 1'b0;
    endtask

    typedef struct packed {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_instr;
    } vec_t;

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                                input logic er, input logic [31:0] ea, input logic eiv,
                                input logic [31:0] eipc, input logic [31:0] ein);
        vec_t r;
        r.rv = rv; r.rpc = rpc; r.rdy = rdy;
        r.e_req = er; r.e_addr = ea; r.e_iv = eiv; r.e_ipc = eipc; r.e_instr = ein;
        return r;
    endfunction

    vec_t vecs [19];

    logic [31:0] exp_pc;
    bit outstanding;
    bit hold_prev;
    int delivered;

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        instr_ready = 1'b0;
        mem_rand = 1'b0;
        mem_lat = 0;

        // Zero-wait memory, decode ready except a 5-cycle stall on 0x8,
        // then a misaligned redirect issued from REQ.
        vecs[0]  = mk(0, 0, 1, 1, 32'h0,   0, 32'h0,   NOP_INSTR);
        vecs[1]  = mk(0, 0, 1, 0, 32'h0,   0, 32'h0,   NOP_INSTR);
        vecs[2]  = mk(0, 0, 1, 0, 32'h4,   1, 32'h0,   mem_word(32'h0));
        vecs[3]  = mk(0, 0, 1, 1, 32'h4,   0, 32'h0,   mem_word(32'h0));
        vecs[4]  = mk(0, 0, 1, 0, 32'h4,   0, 32'h0,   mem_word(32'h0));
        vecs[5]  = mk(0, 0, 1, 0, 32'h8,   1, 32'h4,   mem_word(32'h4));
        vecs[6]  = mk(0, 0, 1, 1, 32'h8,   0, 32'h4,   mem_word(32'h4));
        vecs[7]  = mk(0, 0, 1, 0, 32'h8,   0, 32'h4,   mem_word(32'h4));
        for (int i = 8; i <= 12; i++)
            vecs[i] = mk(0, 0, 0, 0, 32'hC, 1, 32'h8, 32'h0050_0093);
        vecs[13] = mk(0, 0, 1, 0, 32'hC,   1, 32'h8,   32'h0050_0093);
        vecs[14] = mk(1, 32'h103, 1, 0, 32'hC, 0, 32'h8, 32'h0050_0093);
        vecs[15] = mk(0, 0, 1, 1, 32'h100, 0, 32'h8,   32'h0050_0093);
        vecs[16] = mk(0, 0, 1, 0, 32'h100, 0, 32'h8,   32'h0050_0093);
        vecs[17] = mk(0, 0, 1, 0, 32'h104, 1, 32'h100, mem_word(32'h100));
        vecs[18] = mk(0, 0, 1, 1, 32'h104, 0, 32'h100, mem_word(32'h100));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
                            instr_pc_plus4},
            {1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0, 32'h4});
        step();
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive_neg(vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            chk($sformatf("vec%0d", i),
                {imem_req_valid, imem_req_addr, instr_valid, instr_pc, instr_pc_plus4, instr},
                {vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv, vecs[i].e_ipc,
                 vecs[i].e_ipc + 32'd4, vecs[i].e_instr});
            step();
        end

        // Redirect while a request to 0x10 is in flight.
        pulse_reset();
        mem_lat = 2;
        drive_neg(1, 32'h10, 0);  chk("A_req_gated", imem_req_valid, 0); step();
        drive_neg(0, 0, 0);       chk("A_req10", {imem_req_valid, imem_req_addr}, {1'b1, 32'h10});
        step();
        drive_neg(1, 32'h200, 0); chk("A_wait_iv", instr_valid, 0); step();
        drive_neg(0, 0, 0);       chk("A_drop_req", imem_req_valid, 0); step();
        mem_lat = 0;
        drive_neg(0, 0, 0);       chk("A_discard_iv", instr_valid, 0); step();
        drive_neg(0, 0, 0);       chk("A_req200", {imem_req_valid, imem_req_addr}, {1'b1, 32'h200});
        step();
        drive_neg(0, 0, 0);       step();
        drive_neg(0, 0, 1);
        chk("A_deliver", {instr_valid, instr_pc, instr}, {1'b1, 32'h200, mem_word(32'h200)});
        step();

        // Redirect coincident with the response.
        pulse_reset();
        drive_neg(0, 0, 1);       chk("B_req0", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
        step();
        drive_neg(1, 32'h84, 1);  step();
        drive_neg(0, 0, 1);
        chk("B_req84", {imem_req_valid, imem_req_addr, instr_valid}, {1'b1, 32'h84, 1'b0});
        step();
        drive_neg(0, 0, 1);       step();
        drive_neg(0, 0, 1);       chk("B_deliver", {instr_valid, instr_pc}, {1'b1, 32'h84});
        step();

        // Redirect beats a same-cycle consume in HOLD.
        pulse_reset();
        drive_neg(0, 0, 1);       step();
        drive_neg(0, 0, 1);       step();
        drive_neg(1, 32'h84, 1);  chk("C_hold", {instr_valid, instr_pc}, {1'b1, 32'h0}); step();
        drive_neg(0, 0, 1);
        chk("C_req84", {imem_req_valid, imem_req_addr, instr_valid}, {1'b1, 32'h84, 1'b0});
        step();
        drive_neg(0, 0, 1);       step();
        drive_neg(0, 0, 1);       chk("C_deliver", {instr_valid, instr_pc}, {1'b1, 32'h84});
        step();

        // Misaligned redirect to the top word, then PC wrap.
        pulse_reset();
        drive_neg(1, 32'hFFFF_FFFF, 1); step();
        drive_neg(0, 0, 1);
        chk("D_reqtop", {imem_req_valid, imem_req_addr}, {1'b1, 32'hFFFF_FFFC});
        step();
        drive_neg(0, 0, 1);       step();
        drive_neg(0, 0, 1);
        chk("D_hold", {instr_valid, instr_pc, instr_pc_plus4, instr},
            {1'b1, 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC)});
        step();
        drive_neg(0, 0, 1);       chk("D_wrap", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
        step();

        // Async reset while waiting on a slow response.
        pulse_reset();
        drive_neg(1, 32'h40, 1);  step();
        drive_neg(0, 0, 1);       step();
        drive_neg(0, 0, 1);       step();
        drive_neg(0, 0, 1);       chk("E_first", {instr_valid, instr}, {1'b1, mem_word(32'h40)});
        step();
        mem_lat = 3;
        drive_neg(0, 0, 1);       chk("E_req44", {imem_req_valid, imem_req_addr}, {1'b1, 32'h44});
        mem_lat = 0;
        step();
        drive_neg(0, 0, 1);       step();
        pulse_reset();
        drive_neg(0, 0, 1);
        chk("E_after_rst", {imem_req_valid, imem_req_addr, instr}, {1'b1, 32'h0, NOP_INSTR});
        step();
        drive_neg(0, 0, 1);       chk("E_nop_hold", {instr_valid, instr}, {1'b0, NOP_INSTR});
        step();
        drive_neg(0, 0, 1);       chk("E_fetch0", {instr_valid, instr}, {1'b1, mem_word(32'h0)});
        step();

        // Randomized run against a fetch-stream model: the stream restarts at a
        // redirect target (word aligned) and otherwise advances by 4 per consume.
        pulse_reset();
        mem_rand = 1'b1;
        exp_pc = 32'h0;
        outstanding = 1'b0;
        hold_prev = 1'b0;
        delivered = 0;
        for (int n = 0; n < 3000; n++) begin
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
            instr_ready = ($urandom_range(0, 2) != 0);
            mem_lat = $urandom_range(0, 3);
            @(negedge clk);
            if (imem_req_valid) begin
                chk("rnd_req_addr", imem_req_addr, exp_pc);
                chk("rnd_req_busy", {redirect_valid, outstanding, instr_valid}, 0);
            end
            if (instr_valid) begin
                chk("rnd_instr", {instr_pc, instr_pc_plus4, instr},
                    {exp_pc, exp_pc + 32'd4, mem_word(exp_pc)});
            end
            if (hold_prev) chk("rnd_hold", instr_valid, 1);
            if (imem_rsp_valid) outstanding = 1'b0;
            if (imem_req_valid && imem_req_ready) outstanding = 1'b1;
            hold_prev = instr_valid && !instr_ready && !redirect_valid;
            if (redirect_valid) begin
                exp_pc = redirect_pc & ~32'd3;
            end else if (instr_valid && instr_ready) begin
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            step();
        end
        chk("rnd_progress", delivered >= 50, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_ifetch.md
Name: rv32i_ifetch

Overview:
Instruction fetch stage directly upstream of decode. It owns the PC, issues one word request at a time to instruction memory, and accepts the response. It presents the fetched instruction, its PC and PC+4 to decode, with instr[6:0] feeding the main control decoder's opcode input. Branch and jump redirects from execute discard wrong-path fetches and restart at the target.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
XLEN, 32, address and instruction width; only 32 is supported.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts the request this cycle
imem_req_addr  out  32  word-aligned fetch address (= pc)
imem_rsp_valid  in  1  response data valid; one response per accepted request, ≥1 cycle after acceptance
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  taken branch, JAL or JALR from execute
redirect_pc  in  32  redirect target
instr_valid  out  1  instruction available to decode
instr_ready  in  1  decode consumes the instruction this cycle
instr  out  32  instruction word; [6:0] is the opcode to control
instr_pc  out  32  PC of instr
instr_pc_plus4  out  32  instr_pc+4; used as the JAL/JALR link value (mem_to_reg=2)

Behaviour:
- Reset (async assert): state=REQ, pc=RESET_PC, drop=0, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0, instr_pc_plus4=4.
- imem_req_valid is combinational: (state==REQ) && !redirect_valid. It is 0 while rst is high.
- imem_req_addr = pc always.
- At most one outstanding request.
- States:
  - REQ: if redirect_valid, pc<=redirect_pc&~3 and stay in REQ; no request is issued that cycle. Else, if req_valid&&req_ready, go to WAIT. Otherwise stay.
  - WAIT:
    - If rsp_valid and (drop or redirect_valid): discard the response, drop<=0, go to REQ. pc takes redirect_pc&~3 if redirect_valid, else pc is unchanged (already updated).
    - If rsp_valid and no drop or redirect: instr<=rsp_data, instr_pc<=pc, instr_pc_plus4<=pc+4, instr_valid<=1, pc<=pc+4, go to HOLD.
    - If redirect_valid without rsp_valid: pc<=redirect_pc&~3, drop<=1, stay in WAIT.
  - HOLD: instr_valid=1 and outputs stable.
    - If redirect_valid: instr_valid<=0, pc<=redirect_pc&~3, go to REQ. Redirect wins even if instr_ready is high the same cycle; the instruction is not counted as consumed.
    - Else if instr_ready: instr_valid<=0, go to REQ.
- Throughput: 1 instruction per 3 cycles with zero-wait memory and instr_ready held high. Latency from request acceptance to instr_valid is 2 cycles with a 1-cycle memory.
- PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC advances to 0.
- redirect_pc[1:0] is silently cleared; there is no misalign trap.
- Reset mid-operation: all state returns to reset values immediately. A memory response arriving after reset release for a pre-reset request is not distinguishable; memory must also be reset by rst.
- imem_rsp_valid in REQ or HOLD is a protocol violation; it is ignored and flagged by an assertion in the bench.
- Unsupported opcodes pass through unchanged; the control decoder defaults all signals to 0.

Decomposition:
- Add to rv32i_defs.vh: NOP_INSTR (32'h0000_0013), IF_ST_REQ/IF_ST_WAIT/IF_ST_HOLD 2-bit encodings, RESET_PC default.
- Sub-module rv32i_pc_reg: async-reset PC register with next-pc mux (hold / +4 / redirect&~3). The FSM, drop flag and output buffer stay in rv32i_ifetch.

Test Plan:
- Reset then zero-wait memory, instr_ready=1: requests at 0x0, 0x4, 0x8. instr_pc sequence is 0x0, 0x4, 0x8 with instr_pc_plus4 = 0x4, 0x8, 0xC. instr_valid pulses every 3rd cycle.
- Backpressure: hold instr_ready=0 for 5 cycles in HOLD with instr=0x00500093. instr, instr_pc and instr_valid stay stable and no new imem_req_valid is issued. After ready is raised, the next request goes to pc+4.
- Redirect during WAIT: request 0x10 accepted, redirect_pc=0x200 before the response. The response for 0x10 is never presented, and the next request address is 0x200.
- Redirect coincident with the response in WAIT, and redirect with instr_ready=1 in HOLD, both to 0x84. In both cases the instruction is discarded, instr_valid stays 0, and the next request is 0x84.
- Misaligned redirect_pc=0x103 gives next request 0x100. With pc=0xFFFF_FFFC fetched, the next request is 0x0000_0000.
- Async rst pulsed mid-WAIT, between clock edges: instr_valid drops and imem_req_valid=0 immediately. After release, the first request goes to RESET_PC, and instr reads 0x0000_0013 until the first fetch completes.
